// File: rtl/alu_op_sequencer.sv
// Sequencer for the 8-bit relay ALU. It accepts 1000_r_fff instructions and
// holds the function code while the relays settle, then loads the result into A or D and latches the flags.
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic [2:0] alu_func,
  input  logic [7:0] alu_data,
  input  logic       alu_sign,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic [7:0] dest_data,
  output logic       load_a,
  output logic       load_d,
  output logic       flag_sign,
  output logic       flag_carry,
  output logic       flag_zero,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [2:0] FUNC_NOP = 3'b111;
  localparam logic [3:0] CLASS_ALU = 4'b1000;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [2:0]      func;
  logic            dest;
  logic            transfer;
  logic            legal;
  logic            capture;

  assign transfer = instr_valid && (state == IDLE);
  assign legal    = (instr[7:4] == CLASS_ALU);
  assign capture  = (state == SETTLE) && (cnt == {CW{1'b0}});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (transfer && legal) begin
          state_next = SETTLE;
        end else begin
          state_next = IDLE;
        end
      end
      SETTLE: begin
        if (cnt == {CW{1'b0}}) begin
          state_next = IDLE;
        end else begin
          state_next = SETTLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state register; the bus is released outside SETTLE
  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b0;
    alu_func    = FUNC_NOP;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
      end
      SETTLE: begin
        busy     = 1'b1;
        alu_func = func;
      end
      default: begin
        alu_func = FUNC_NOP;
      end
    endcase
  end

  // Instruction latch, settle counter, result capture and one-cycle strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= {CW{1'b0}};
      func       <= FUNC_NOP;
      dest       <= 1'b0;
      dest_data  <= 8'h00;
      load_a     <= 1'b0;
      load_d     <= 1'b0;
      flag_sign  <= 1'b0;
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      load_a  <= 1'b0;
      load_d  <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      if (transfer) begin
        if (legal) begin
          func <= instr[2:0];
          dest <= instr[3];
          cnt  <= CNT_LOAD;
        end else begin
          illegal <= 1'b1;
        end
      end else if (capture) begin
        done <= 1'b1;
        // NOP completes without touching the register file or the flags
        if (func != FUNC_NOP) begin
          dest_data  <= alu_data;
          load_a     <= ~dest;
          load_d     <= dest;
          flag_sign  <= alu_sign;
          flag_carry <= alu_carry;
          flag_zero  <= alu_zero;
        end else begin
          dest_data  <= dest_data;
        end
      end else if (state == SETTLE) begin
        cnt <= cnt - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        cnt <= cnt;
      end
    end
  end

endmodule
